nes_line_doubler: RTL and testbench
===================================

// Module: nes_line_doubler
// PURPOSE
//  Ping-pong line buffer and palette stage directly upstream of the VGA driver.
//  Captures 256-pixel PPU scanlines (6-bit colour index) and replays each one to
//  the driver as a 512-pixel, 15-bit {B,G,R} line. The driver's next_pixel_x is
//  the read address. Also generates the driver's one-cycle frame sync and
//  blanks output while no PPU frame timing is present.
// PARAMETERS
//  SYNC_LINE       261        PPU line whose start issues vga_sync (pre-render)
//  TIMEOUT_CYCLES  1_000_000  clk cycles without a frame start before lock loss
//  TO_W            20         watchdog counter width (2^TO_W > TIMEOUT_CYCLES)
// PORTS
//  clk          in   1   system clock; every register is on its rising edge
//  reset        in   1   synchronous, active-high reset
//  ppu_we       in   1   PPU pixel strobe; colour/x/y are valid while high
//  ppu_color    in   6   NES palette index
//  ppu_x        in   9   PPU pixel column; writes only when ppu_x < 256
//  ppu_y        in   9   PPU scanline number, 0..261
//  next_pixel_x in   10  from driver: [9] = read bank, [8:1] = column, [0] ignored
//  pixel        out  15  {B[14:10],G[9:5],R[4:0]} for the address presented last cycle
//  vga_sync     out  1   one-cycle frame-start pulse to the driver's sync input
//  locked       out  1   high while PPU frame timing is present
// BEHAVIOUR
//  Reset: pixel=0, vga_sync=0, locked=0, state=UNLOCKED, watchdog=0, prev_y=0.
//  Buffer RAM contents are undefined after reset.
//  Buffer: 2 banks x 256 x 6 bits.
//   Write: ppu_we && ppu_x<256 writes bank ppu_y[0], address ppu_x[7:0].
//   Read: registered, addr {next_pixel_x[9], next_pixel_x[8:1]}. Each PPU pixel
//    therefore appears on 2 consecutive columns.
//   Same-address read and write in one cycle: the read returns the OLD data.
//  Latency: address at edge N -> pixel valid after edge N+1 (1 cycle).
//   Palette lookup is combinational from the registered index, then registered.
//  Frame start (fs):
//   - prev_y tracks ppu_y on every cycle ppu_we is high.
//   - fs = ppu_we && ppu_y==SYNC_LINE && prev_y!=SYNC_LINE.
//   - vga_sync=1 the cycle after fs, for exactly one cycle; the next fs is
//     needed for another pulse.
//  Lock FSM:
//   UNLOCKED -> LOCKED on fs; watchdog clears.
//   LOCKED: watchdog increments each cycle and clears on fs. When it reaches
//    TIMEOUT_CYCLES-1 -> UNLOCKED, watchdog clears, no vga_sync.
//   locked = (state==LOCKED). In UNLOCKED, the pixel register loads 0 and
//    vga_sync still pulses on fs.
//   fs in the same cycle as expiry: fs wins and the FSM stays LOCKED.
//  Wrap: ppu_y 261->0 is not a frame start unless SYNC_LINE==0. Columns
//   ppu_x>=256 (HBlank) are ignored.
//  Reset asserted mid-line: the FSM, watchdog, pixel and vga_sync return to
//   reset values on the next edge; RAM is left as is.
// CONFIGURATION
//  SCANLINES_EN defined:
//   - next_pixel_x[9] alone does not identify odd lines, so the block keeps a
//     line-parity flop. It toggles whenever next_pixel_x[8:0] wraps 511->0 and
//     clears on vga_sync.
//   - When parity=1, each RGB channel of pixel is shifted right by 1 (50% dim).
//  SCANLINES_EN undefined: no parity flop; all lines full intensity.
// STRUCTURE
//  Package nes_video_pkg:
//   - rgb15_t, color_idx_t
//   - NES_LINE_W=256, VGA_LINE_W=512
//   - the 64-entry palette constant NES_PALETTE[0:63]
//  Sub-module nes_palette_rom: combinational 6->15-bit lookup of NES_PALETTE.
//  Line RAM is inferred in this module as a simple dual-port array.
// TESTING
//  1. After reset, drive a frame (y=261 then 0..239) with colour=x[5:0]. Set
//     next_pixel_x={bank,x,1'b0}: pixel one cycle later = NES_PALETTE[x[5:0]].
//     Addresses {b,x,0} and {b,x,1} return the same value.
//  2. Write bank0 x=10 with 0x21 and read the same address in the same cycle:
//     pixel = the old value. Read the next cycle: NES_PALETTE[0x21].
//  3. ppu_y steps 260->261 with ppu_we: vga_sync high for exactly one cycle,
//     one cycle later. Holding y=261 gives no further pulse. y 261->0 gives
//     no pulse.
//  4. Reach LOCKED, then stop ppu_we. locked falls after exactly
//     TIMEOUT_CYCLES cycles and pixel reads 0. A new fs relocks.
//  5. ppu_we with ppu_x=300 leaves bank contents unchanged. Assert reset
//     mid-line: next edge pixel=0, locked=0, vga_sync=0.
//  6. With SCANLINES_EN, colour 0x30 (R=G=B=31): the first line after sync
//     reads 31, the next line 15 (0x3DEF).

Source files
------------

// File: rtl/nes_video_pkg.sv
// Shared video types, line geometry and the NES 2C02 palette in 15-bit {B,G,R} form.
// Used by nes_palette_rom and nes_line_doubler.
package nes_video_pkg;

  typedef logic [14:0] rgb15_t;
  typedef logic [5:0]  color_idx_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  localparam int NES_LINE_W = 256;
  localparam int VGA_LINE_W = 512;

  // Each entry is {B,G,R}, 5 bits per channel; the 0x2D/0x3D greys and 0x20/0x30 whites are neutral.
  localparam rgb15_t NES_PALETTE [0:63] = '{
    {5'd11, 5'd11, 5'd11}, {5'd15, 5'd4,  5'd0 }, {5'd19, 5'd2,  5'd1 }, {5'd18, 5'd0,  5'd6 },
    {5'd13, 5'd0,  5'd9 }, {5'd6,  5'd0,  5'd12}, {5'd0,  5'd1,  5'd11}, {5'd0,  5'd3,  5'd8 },
    {5'd0,  5'd6,  5'd4 }, {5'd0,  5'd8,  5'd1 }, {5'd0,  5'd8,  5'd0 }, {5'd0,  5'd8,  5'd0 },
    {5'd8,  5'd7,  5'd0 }, {5'd0,  5'd0,  5'd0 }, {5'd0,  5'd0,  5'd0 }, {5'd0,  5'd0,  5'd0 },
    {5'd20, 5'd20, 5'd20}, {5'd26, 5'd10, 5'd1 }, {5'd31, 5'd7,  5'd6 }, {5'd30, 5'd4,  5'd12},
    {5'd23, 5'd3,  5'd18}, {5'd13, 5'd3,  5'd21}, {5'd4,  5'd4,  5'd20}, {5'd0,  5'd8,  5'd16},
    {5'd0,  5'd12, 5'd11}, {5'd0,  5'd15, 5'd5 }, {5'd0,  5'd16, 5'd1 }, {5'd5,  5'd16, 5'd0 },
    {5'd16, 5'd13, 5'd0 }, {5'd0,  5'd0,  5'd0 }, {5'd0,  5'd0,  5'd0 }, {5'd0,  5'd0,  5'd0 },
    {5'd31, 5'd31, 5'd31}, {5'd31, 5'd20, 5'd10}, {5'd31, 5'd16, 5'd16}, {5'd31, 5'd13, 5'd23},
    {5'd31, 5'd11, 5'd30}, {5'd24, 5'd12, 5'd31}, {5'd13, 5'd14, 5'd31}, {5'd4,  5'd18, 5'd28},
    {5'd0,  5'd22, 5'd21}, {5'd0,  5'd26, 5'd15}, {5'd4,  5'd27, 5'd10}, {5'd14, 5'd27, 5'd7 },
    {5'd27, 5'd24, 5'd7 }, {5'd8,  5'd8,  5'd8 }, {5'd0,  5'd0,  5'd0 }, {5'd0,  5'd0,  5'd0 },
    {5'd31, 5'd31, 5'd31}, {5'd31, 5'd27, 5'd22}, {5'd31, 5'd25, 5'd25}, {5'd31, 5'd23, 5'd28},
    {5'd31, 5'd23, 5'd31}, {5'd28, 5'd23, 5'd31}, {5'd23, 5'd24, 5'd31}, {5'd19, 5'd26, 5'd30},
    {5'd16, 5'd28, 5'd27}, {5'd16, 5'd29, 5'd24}, {5'd19, 5'd30, 5'd22}, {5'd24, 5'd30, 5'd20},
    {5'd30, 5'd28, 5'd21}, {5'd21, 5'd21, 5'd21}, {5'd0,  5'd0,  5'd0 }, {5'd0,  5'd0,  5'd0 }
  };

endpackage

// File: rtl/nes_palette_rom.sv
// Combinational 6-bit NES colour index to 15-bit {B,G,R} lookup.
module nes_palette_rom
  import nes_video_pkg::*;
(
  input  color_idx_t i_idx,
  output rgb15_t     o_rgb
);

  assign o_rgb = NES_PALETTE[i_idx];

endmodule

// File: rtl/nes_line_doubler.sv
// Ping-pong scanline buffer + palette stage feeding the VGA driver; also issues the
// driver's frame sync and tracks PPU lock. Optional SCANLINES_EN dims every other line.
module nes_line_doubler
  import nes_video_pkg::*;
#(
  parameter int SYNC_LINE      = 261,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_W           = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ppu_we,
  input  logic [5:0]  ppu_color,
  input  logic [8:0]  ppu_x,
  input  logic [8:0]  ppu_y,
  input  logic [9:0]  next_pixel_x,
  output logic [14:0] pixel,
  output logic        vga_sync,
  output logic        locked
);

  color_idx_t  r_ram [0:511];
  color_idx_t  r_rd_idx;
  logic [8:0]  w_wr_addr;
  logic [8:0]  w_rd_addr;
  rgb15_t      w_pal_rgb;
  rgb15_t      w_shaded;
  rgb15_t      w_pix_next;
  rgb15_t      r_pixel;
  logic        r_vga_sync;
  logic [8:0]  r_prev_y;
  logic        w_fs;
  lock_state_t r_state;
  lock_state_t w_state_next;
  logic [TO_W-1:0] r_wd;
  logic [TO_W-1:0] w_wd_next;

  // Bank is the PPU line parity; the driver's bit 0 halves the 512-wide VGA column.
  assign w_wr_addr = {ppu_y[0], ppu_x[7:0]};
  assign w_rd_addr = {next_pixel_x[9], next_pixel_x[8:1]};

  always_ff @(posedge clk) begin
    if (ppu_we && (ppu_x < 9'(NES_LINE_W))) begin
      r_ram[w_wr_addr] <= ppu_color;
    end
    r_rd_idx <= r_ram[w_rd_addr];
  end

  nes_palette_rom u_palette (
    .i_idx (r_rd_idx),
    .o_rgb (w_pal_rgb)
  );

  assign w_fs = ppu_we && (ppu_y == 9'(SYNC_LINE)) && (r_prev_y != 9'(SYNC_LINE));

`ifdef SCANLINES_EN
  logic [8:0] r_prev_col;
  logic       r_parity;
  logic       w_wrap;

  assign w_wrap = (r_prev_col == 9'(VGA_LINE_W - 1)) && (next_pixel_x[8:0] == 9'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_col <= '0;
      r_parity   <= 1'b0;
    end else begin
      r_prev_col <= next_pixel_x[8:0];
      if (r_vga_sync) begin
        r_parity <= 1'b0;
      end else if (w_wrap) begin
        r_parity <= ~r_parity;
      end
    end
  end

  assign w_shaded = r_parity ? {1'b0, w_pal_rgb[14:11], 1'b0, w_pal_rgb[9:6], 1'b0, w_pal_rgb[4:1]}
                             : w_pal_rgb;
`else
  logic w_unused_npx0;
  assign w_unused_npx0 = next_pixel_x[0];
  assign w_shaded      = w_pal_rgb;
`endif

  // A frame start always wins over watchdog expiry.
  always_comb begin
    w_state_next = r_state;
    w_wd_next    = r_wd;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_fs) begin
          w_state_next = ST_LOCKED;
          w_wd_next    = '0;
        end
      end
      ST_LOCKED: begin
        if (w_fs) begin
          w_wd_next = '0;
        end else if (r_wd == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_next = ST_UNLOCKED;
          w_wd_next    = '0;
        end else begin
          w_wd_next = r_wd + TO_W'(1);
        end
      end
      default: begin
        w_state_next = ST_UNLOCKED;
        w_wd_next    = '0;
      end
    endcase
  end

  assign w_pix_next = (r_state == ST_LOCKED) ? w_shaded : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_UNLOCKED;
      r_wd       <= '0;
      r_prev_y   <= '0;
      r_pixel    <= '0;
      r_vga_sync <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wd       <= w_wd_next;
      r_pixel    <= w_pix_next;
      r_vga_sync <= w_fs;
      if (ppu_we) begin
        r_prev_y <= ppu_y;
      end
    end
  end

  assign pixel    = r_pixel;
  assign vga_sync = r_vga_sync;
  assign locked   = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_nes_line_doubler.sv
// Scoreboard bench for nes_line_doubler: a per-cycle reference model pushes expected
// {check, locked, vga_sync, pixel} entries; a monitor pops and compares after each edge.
module tb_nes_line_doubler;

  localparam int T    = 2000;
  localparam int TW   = 11;
  localparam int SYNC = 261;

  logic        clk = 1'b0;
  logic        reset;
  logic        ppu_we;
  logic [5:0]  ppu_color;
  logic [8:0]  ppu_x;
  logic [8:0]  ppu_y;
  logic [9:0]  next_pixel_x;
  logic [14:0] pixel;
  logic        vga_sync;
  logic        locked;

  always #5 clk = ~clk;

  nes_line_doubler #(
    .SYNC_LINE      (SYNC),
    .TIMEOUT_CYCLES (T),
    .TO_W           (TW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ppu_we       (ppu_we),
    .ppu_color    (ppu_color),
    .ppu_x        (ppu_x),
    .ppu_y        (ppu_y),
    .next_pixel_x (next_pixel_x),
    .pixel        (pixel),
    .vga_sync     (vga_sync),
    .locked       (locked)
  );

  // Reference palette as {R,G,B} triples, 5-bit channel intensities.
  int pal_tab [192] = '{
    11,11,11,  0,4,15,   1,2,19,   6,0,18,   9,0,13,   12,0,6,   11,1,0,   8,3,0,
    4,6,0,     1,8,0,    0,8,0,    0,8,0,    0,7,8,    0,0,0,    0,0,0,    0,0,0,
    20,20,20,  1,10,26,  6,7,31,   12,4,30,  18,3,23,  21,3,13,  20,4,4,   16,8,0,
    11,12,0,   5,15,0,   1,16,0,   0,16,5,   0,13,16,  0,0,0,    0,0,0,    0,0,0,
    31,31,31,  10,20,31, 16,16,31, 23,13,31, 30,11,31, 31,12,24, 31,14,13, 28,18,4,
    21,22,0,   15,26,0,  10,27,4,  7,27,14,  7,24,27,  8,8,8,    0,0,0,    0,0,0,
    31,31,31,  22,27,31, 25,25,31, 28,23,31, 31,23,31, 31,23,28, 31,24,23, 30,26,19,
    27,28,16,  24,29,16, 22,30,19, 20,30,24, 21,28,30, 21,21,21, 0,0,0,    0,0,0
  };

  function automatic logic [14:0] ref_pal(input logic [5:0] c, input bit dim);
    int r, g, b;
    r = pal_tab[3*int'(c)];
    g = pal_tab[3*int'(c)+1];
    b = pal_tab[3*int'(c)+2];
    if (dim) begin
      r = r / 2;
      g = g / 2;
      b = b / 2;
    end
    return 15'(b*1024 + g*32 + r);
  endfunction

  // Reference model state
  logic [5:0] m_mem [2][256];
  bit         m_val [2][256];
  int         m_edge;
  int         m_last_fs;
  bit         m_have_fs;
  bit         m_locked;
  logic [8:0] m_prev_y;
  logic [5:0] m_rd_idx;
  bit         m_rd_known;
  bit         m_sync;
  bit         m_parity;
  logic [8:0] m_prev_col;

  logic [17:0] exp_q [$];
  int n_tests;
  int n_fail;

  task automatic model_edge();
    logic [14:0] pix;
    bit chk, fs, lk;
    m_edge++;
    if (reset) begin
      pix = '0; chk = 1'b1; fs = 1'b0; lk = 1'b0;
      m_prev_y  = '0;
      m_have_fs = 1'b0;
    end else begin
      chk = m_locked ? m_rd_known : 1'b1;
      pix = m_locked ? ref_pal(m_rd_idx, m_parity) : 15'd0;
      fs  = ppu_we && (ppu_y == 9'(SYNC)) && (m_prev_y != 9'(SYNC));
      if (ppu_we) m_prev_y = ppu_y;
      if (fs) begin
        m_have_fs = 1'b1;
        m_last_fs = m_edge;
      end
      lk = m_have_fs && ((m_edge - m_last_fs) < T);
    end
`ifdef SCANLINES_EN
    if (reset) begin
      m_parity   = 1'b0;
      m_prev_col = '0;
    end else begin
      if (m_sync) m_parity = 1'b0;
      else if (m_prev_col == 9'd511 && next_pixel_x[8:0] == 9'd0) m_parity = ~m_parity;
      m_prev_col = next_pixel_x[8:0];
    end
`endif
    m_rd_idx   = m_mem[next_pixel_x[9]][next_pixel_x[8:1]];
    m_rd_known = m_val[next_pixel_x[9]][next_pixel_x[8:1]];
    if (ppu_we && ppu_x < 9'd256) begin
      m_mem[ppu_y[0]][ppu_x[7:0]] = ppu_color;
      m_val[ppu_y[0]][ppu_x[7:0]] = 1'b1;
    end
    m_sync   = fs;
    m_locked = lk;
    exp_q.push_back({chk, lk, fs, pix});
  endtask

  // Called at a negedge: drive inputs, model the coming edge, wait to the next negedge.
  task automatic step(input logic we, input logic [5:0] c, input logic [8:0] x,
                      input logic [8:0] y, input logic [9:0] npx);
    ppu_we       = we;
    ppu_color    = c;
    ppu_x        = x;
    ppu_y        = y;
    next_pixel_x = npx;
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [9:0] rnpx(input logic b);
    return {b, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1))};
  endfunction

  task automatic sync_pair();
    step(1'b1, 6'd0, 9'd300, 9'd260, rnpx(1'b0));
    step(1'b1, 6'd0, 9'd300, 9'd261, rnpx(1'b1));
  endtask

  // Monitor: one expected entry per clock edge.
  initial begin
    logic [17:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (vga_sync !== e[15]) begin
          n_fail++;
          $display("FAIL vga_sync @%0t: got %b expected %b", $time, vga_sync, e[15]);
        end
        n_tests++;
        if (locked !== e[16]) begin
          n_fail++;
          $display("FAIL locked @%0t: got %b expected %b", $time, locked, e[16]);
        end
        if (e[17]) begin
          n_tests++;
          if (pixel !== e[14:0]) begin
            n_fail++;
            $display("FAIL pixel @%0t: got %h expected %h", $time, pixel, e[14:0]);
          end
        end
      end
    end
  end

  initial begin
    int cnt;
    n_tests = 0; n_fail = 0;
    m_edge = 0; m_last_fs = 0; m_have_fs = 0; m_locked = 0;
    m_prev_y = '0; m_rd_idx = '0; m_rd_known = 0; m_sync = 0; m_parity = 0; m_prev_col = '0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++) begin
        m_mem[b][a] = '0;
        m_val[b][a] = 1'b0;
      end
    reset = 1'b1; ppu_we = 0; ppu_color = 0; ppu_x = 0; ppu_y = 0; next_pixel_x = 0;
    @(negedge clk);

    // Reset state
    repeat (3) step(1'b0, 6'd0, 9'd0, 9'd0, rnpx(1'b0));
    reset = 1'b0;

    // Frame start, held pre-render line, then wrap to line 0
    sync_pair();
    for (int i = 0; i < 5; i++) step(1'b1, 6'($urandom), 9'(i), 9'd261, rnpx(1'b0));
    step(1'b1, 6'd0, 9'd300, 9'd0, rnpx(1'b0));

    // Lines with HBlank columns; read back the previous line's bank
    for (int line = 0; line < 8; line++) begin
      if (line % 3 == 2) sync_pair();
      for (int x = 0; x < 300; x++) begin
        step(1'b1, (line % 2 == 0) ? 6'(x) : 6'($urandom), 9'(x), 9'(line),
             rnpx(1'(line + 1)));
      end
    end

    // Same-cycle write/read of bank0 column 10 returns old data, then new
    sync_pair();
    step(1'b1, 6'h21, 9'd10, 9'd0, {1'b0, 8'd10, 1'b0});
    step(1'b0, 6'd0, 9'd0, 9'd0, {1'b0, 8'd10, 1'b1});
    step(1'b0, 6'd0, 9'd0, 9'd0, {1'b0, 8'd10, 1'b0});
    step(1'b0, 6'd0, 9'd0, 9'd0, rnpx(1'b0));

    // Watchdog expiry measured from the last frame start
    sync_pair();
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_after_fs: got %b expected 1", locked);
    end
    cnt = 0;
    while (locked === 1'b1 && cnt < T + 20) begin
      step(1'b0, 6'd0, 9'd0, 9'd0, rnpx(1'($urandom)));
      cnt++;
    end
    n_tests++;
    if (cnt != T) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d cycles expected %0d", cnt, T);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 6'd0, 9'd0, 9'd0, rnpx(1'($urandom)));

    // Relock, then reset mid-line
    sync_pair();
    for (int x = 0; x < 100; x++) begin
      if (x == 50) begin
        reset = 1'b1;
        step(1'b0, 6'd0, 9'd0, 9'd0, rnpx(1'b1));
        reset = 1'b0;
      end
      step(1'b1, 6'($urandom), 9'(x), 9'd2, rnpx(1'b1));
    end
    sync_pair();
    for (int i = 0; i < 100; i++) step(1'b0, 6'd0, 9'd0, 9'd0, {1'b0, 8'(i), 1'($urandom)});

`ifdef SCANLINES_EN
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 256; x++) step(1'b1, 6'h30, 9'(x), 9'(y), rnpx(1'b0));
    sync_pair();
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 512; i++) step(1'b0, 6'd0, 9'd0, 9'd0, {1'(l), 9'(i)});
`endif

    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
